// File: rtl/reg_fifo_sync.sv
// Single-clock register-cell FIFO with occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow error flags.
module reg_fifo_sync #(
    parameter int N_BITS   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enable_put,
    input  logic [N_BITS-1:0] data_put,
    input  logic              enable_get,
    output logic [N_BITS-1:0] data_get,
    output logic              valid_get,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [N_BITS-1:0] cells [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              put_ok;
    logic              get_ok;
    logic [CNT_W-1:0]  count_nxt;

    // Explicit wrap compare keeps non-power-of-two depths legal.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign put_ok = enable_put && !full;
    assign get_ok = enable_get && !empty;

    always_comb begin
        count_nxt = count;
        case ({put_ok, get_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cells[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_get     <= '0;
            valid_get    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            // Storage, data_get and error flags are left as they are.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            valid_get    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_CNT == '0);
            almost_empty <= 1'b1;
        end else begin
            if (put_ok) begin
                cells[wr_ptr] <= data_put;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (get_ok) begin
                data_get <= cells[rd_ptr];
                rd_ptr   <= next_ptr(rd_ptr);
            end
            valid_get    <= get_ok;
            count        <= count_nxt;
            full         <= (count_nxt == FULL_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            overflow     <= overflow  | (enable_put && full);
            underflow    <= underflow | (enable_get && empty);
        end
    end

endmodule

// File: tb/tb_reg_fifo_sync.sv
// Directed bench for reg_fifo_sync: default DEPTH=8 instance plus a DEPTH=5
// instance used for the pointer-wrap scenario.
module tb_reg_fifo_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enable_put = 1'b0;
    logic [31:0] data_put = '0;
    logic        enable_get = 1'b0;
    logic [31:0] data_get;
    logic        valid_get, full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    logic        flush5 = 1'b0;
    logic        put5 = 1'b0;
    logic [7:0]  dput5 = '0;
    logic        get5 = 1'b0;
    logic [7:0]  dget5;
    logic        vget5, full5, empty5, af5, ae5;
    logic [2:0]  count5;
    logic        of5, uf5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_fifo_sync dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enable_put(enable_put), .data_put(data_put), .enable_get(enable_get),
        .data_get(data_get), .valid_get(valid_get), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    reg_fifo_sync #(.N_BITS(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
        .clk(clk), .reset(reset), .flush(flush5),
        .enable_put(put5), .data_put(dput5), .enable_get(get5),
        .data_get(dget5), .valid_get(vget5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .count(count5),
        .overflow(of5), .underflow(uf5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({count, full, empty, almost_full, almost_empty, valid_get, overflow, underflow} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d f=%b e=%b af=%b ae=%b v=%b of=%b uf=%b, expected cnt=0 f=0 e=1 af=0 ae=1 v=0 of=0 uf=0",
                     count, full, empty, almost_full, almost_empty, valid_get, overflow, underflow);
        end
        checks++;
        if (data_get !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00000000", data_get);
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_flags;
        for (int i = 1; i <= 8; i++) begin
            enable_put = 1'b1;
            data_put   = 32'(i);
            tick();
            exp_flags = {(i == 8), 1'b0, (i >= 6), (i <= 2)};
            checks++;
            if (count !== 4'(i) || {full, empty, almost_full, almost_empty} !== exp_flags) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d flags(f,e,af,ae)=%b expected cnt=%0d flags=%b",
                         i, count, {full, empty, almost_full, almost_empty}, i, exp_flags);
            end
        end
        enable_put = 1'b0;
    endtask

    task automatic test_overflow();
        enable_put = 1'b1;
        data_put   = 32'hDEAD;
        tick();
        enable_put = 1'b0;
        checks++;
        if ({overflow, underflow, full, count} !== {1'b1, 1'b0, 1'b1, 4'd8}) begin
            errors++;
            $display("FAIL overflow_set: of=%b uf=%b f=%b cnt=%0d expected of=1 uf=0 f=1 cnt=8",
                     overflow, underflow, full, count);
        end
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_drain();
        enable_get = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (valid_get !== 1'b1 || data_get !== 32'(k) || count !== 4'(8 - k)) begin
                errors++;
                $display("FAIL drain_%0d: v=%b data=%h cnt=%0d expected v=1 data=%h cnt=%0d",
                         k, valid_get, data_get, count, 32'(k), 8 - k);
            end
        end
        enable_get = 1'b0;
        checks++;
        if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            errors++;
            $display("FAIL drain_flags: e,ae,f,af=%b expected 1100",
                     {empty, almost_empty, full, almost_full});
        end
        tick();
        checks++;
        if (valid_get !== 1'b0 || data_get !== 32'h8) begin
            errors++;
            $display("FAIL drain_hold: v=%b data=%h expected v=0 data=00000008", valid_get, data_get);
        end
    endtask

    task automatic test_underflow();
        enable_get = 1'b1;
        tick();
        enable_get = 1'b0;
        checks++;
        if ({underflow, valid_get, count} !== {1'b1, 1'b0, 4'd0} || data_get !== 32'h8) begin
            errors++;
            $display("FAIL underflow: uf=%b v=%b cnt=%0d data=%h expected uf=1 v=0 cnt=0 data=00000008",
                     underflow, valid_get, count, data_get);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] pre [3];
        logic [31:0] exp_rd [4];
        pre    = '{32'h11, 32'h22, 32'h33};
        exp_rd = '{32'h11, 32'h22, 32'h33, 32'hA5};
        for (int i = 0; i < 3; i++) begin
            enable_put = 1'b1;
            data_put   = pre[i];
            tick();
        end
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL simul_prefill: cnt=%0d expected 3", count);
        end
        enable_get = 1'b1;
        data_put   = 32'hA5;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (valid_get !== 1'b1 || data_get !== exp_rd[k] || count !== 4'd3) begin
                errors++;
                $display("FAIL simul_%0d: v=%b data=%h cnt=%0d expected v=1 data=%h cnt=3",
                         k, valid_get, data_get, count, exp_rd[k]);
            end
        end
        enable_put = 1'b0;
        enable_get = 1'b0;
    endtask

    task automatic test_flush_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({overflow, underflow, count} !== {1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_prereset: of=%b uf=%b cnt=%0d expected 0 0 0", overflow, underflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            enable_put = 1'b1;
            data_put   = 32'h40 + 32'(i);
            tick();
        end
        flush    = 1'b1;
        data_put = 32'hEE;
        tick();
        flush      = 1'b0;
        enable_put = 1'b0;
        checks++;
        if ({count, empty, almost_empty, full, overflow, underflow, valid_get} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_put: cnt=%0d e=%b ae=%b f=%b of=%b uf=%b v=%b expected cnt=0 e=1 ae=1 f=0 of=0 uf=0 v=0",
                     count, empty, almost_empty, full, overflow, underflow, valid_get);
        end
        flush      = 1'b1;
        enable_get = 1'b1;
        tick();
        flush      = 1'b0;
        checks++;
        if (underflow !== 1'b0 || valid_get !== 1'b0) begin
            errors++;
            $display("FAIL flush_get: uf=%b v=%b expected uf=0 v=0", underflow, valid_get);
        end
        enable_put = 1'b1;
        data_put   = 32'h77;
        tick();
        checks++;
        if ({count, valid_get, underflow, empty} !== {4'd1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL empty_putget: cnt=%0d v=%b uf=%b e=%b expected cnt=1 v=0 uf=1 e=0",
                     count, valid_get, underflow, empty);
        end
        enable_get = 1'b0;
        data_put   = 32'h88;
        tick();
        enable_put = 1'b0;
        enable_get = 1'b1;
        tick();
        checks++;
        if (valid_get !== 1'b1 || data_get !== 32'h77 || count !== 4'd1) begin
            errors++;
            $display("FAIL refill_read: v=%b data=%h cnt=%0d expected v=1 data=00000077 cnt=1",
                     valid_get, data_get, count);
        end
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        enable_get = 1'b0;
        checks++;
        if ({count, full, empty, almost_full, almost_empty, valid_get, overflow, underflow} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0} || data_get !== 32'h0) begin
            errors++;
            $display("FAIL midstream_reset: cnt=%0d f=%b e=%b af=%b ae=%b v=%b of=%b uf=%b data=%h expected reset values",
                     count, full, empty, almost_full, almost_empty, valid_get, overflow, underflow, data_get);
        end
    endtask

    task automatic test_wrap_depth5();
        logic [7:0] exp_rd;
        logic [7:0] tail [5];
        tail = '{8'h19, 8'h1A, 8'h1B, 8'h20, 8'h21};
        for (int i = 0; i < 3; i++) begin
            put5  = 1'b1;
            dput5 = 8'(i + 1);
            tick();
        end
        get5 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dput5 = 8'h10 + 8'(i);
            tick();
            exp_rd = (i < 3) ? 8'(i + 1) : 8'h10 + 8'(i - 3);
            checks++;
            if (vget5 !== 1'b1 || dget5 !== exp_rd || count5 !== 3'd3) begin
                errors++;
                $display("FAIL wrap_%0d: v=%b data=%h cnt=%0d expected v=1 data=%h cnt=3",
                         i, vget5, dget5, count5, exp_rd);
            end
        end
        get5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dput5 = 8'h20 + 8'(i);
            tick();
        end
        put5 = 1'b0;
        checks++;
        if ({count5, full5, af5, of5} !== {3'd5, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_full: cnt=%0d f=%b af=%b of=%b expected cnt=5 f=1 af=1 of=1",
                     count5, full5, af5, of5);
        end
        get5 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (vget5 !== 1'b1 || dget5 !== tail[k]) begin
                errors++;
                $display("FAIL wrap_drain_%0d: v=%b data=%h expected v=1 data=%h", k, vget5, dget5, tail[k]);
            end
        end
        get5 = 1'b0;
        checks++;
        if ({count5, empty5, ae5, uf5} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_end: cnt=%0d e=%b ae=%b uf=%b expected cnt=0 e=1 ae=1 uf=0",
                     count5, empty5, ae5, uf5);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_simultaneous();
        test_flush_reset();
        test_wrap_depth5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_fifo_sync.md
Name: reg_fifo_sync

Overview:
- Single-clock FIFO built from DEPTH N_BITS-wide register cells; the parametrised successor to the single-entry put/get register cell.
- Adds depth, read/write pointers, occupancy count, full/empty/almost thresholds, a flush and sticky overflow/underflow error flags.
- Sits between same-clock producer and consumer stages of the datapath; the mixed-clock FIFO keeps its own cells.

Parameters:
- N_BITS, 32, data word width (>=1).
- DEPTH, 8, number of entries (>=2; power of two not required).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- CNT_W, $clog2(DEPTH+1), width of count (derived; do not override).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk; priority over all other inputs.
- flush  input  1  synchronous empty request; pointers/count to 0, storage untouched.
- enable_put  input  1  write request.
- data_put  input  N_BITS  write data.
- enable_get  input  1  read request.
- data_get  output  N_BITS  registered read data.
- valid_get  output  1  one-cycle pulse: data_get updated this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  CNT_W  current occupancy 0..DEPTH.
- overflow  output  1  sticky: put attempted while full.
- underflow  output  1  sticky: get attempted while empty.

Behaviour:
- Reset (reset=1 at posedge): all storage cells, wr_ptr, rd_ptr, count, data_get to 0. valid_get, full, overflow, underflow, almost_full to 0. empty to 1. almost_empty to 1.
- Put accepted (put_ok) iff enable_put && !full, evaluated on the pre-edge state. Writes data_put to cell[wr_ptr]; wr_ptr advances next edge.
- Get accepted (get_ok) iff enable_get && !empty, evaluated on the pre-edge state. data_get <= cell[rd_ptr] at that edge; valid_get=1 for the following cycle; rd_ptr advances.
- Read latency: 1 cycle from the accepting edge. Data is not first-word-fall-through. data_get holds its value when no get is accepted. valid_get is 0 when no get is accepted.
- Pointer wrap: ptr == DEPTH-1 goes to 0 on advance. This is explicit compare, not modulo-2^k, so non-power-of-two DEPTH is legal.
- count update: +1 on put_ok only, -1 on get_ok only, unchanged when both or neither.
- Simultaneous put+get:
  - Empty: only the put is accepted; underflow sets; no bypass to data_get.
  - Full: only the get is accepted; overflow sets; the rejected put is dropped and not retried.
  - Otherwise both are accepted and count is unchanged.
- full, empty, almost_full and almost_empty are registered, derived from the next count, and consistent with count every cycle.
- overflow/underflow: set on a rejected request and held until reset. flush does not clear them.
- flush (reset=0): wr_ptr, rd_ptr, count go to 0; empty goes to 1; valid_get goes to 0; data_get holds. A put or get in the same cycle as flush is ignored and does not set error flags.
- Priority: reset > flush > put/get.
- Reset mid-operation: any in-flight word is discarded; valid_get is never asserted the cycle after reset.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then fill: reset 2 cycles; put 0x1..0x8 on consecutive cycles -> count steps 1..8; almost_full rises when count reaches 6; full=1 after the 8th; empty=0 after the 1st.
- Drain order: from full, enable_get for 8 cycles -> data_get 0x1..0x8 each one cycle after its accepting edge; valid_get high 8 cycles; empty=1 and almost_empty=1 at end.
- Overflow/underflow: put 0xDEAD while full -> overflow=1 and stays set, count stays 8, 0xDEAD never read. Get while empty -> underflow=1, valid_get=0.
- Simultaneous put+get: at count=3, put 0xA5 with get for 4 cycles -> count stays 3; reads return the oldest words in order.
- Wrap, DEPTH=5 build: 12 put/get interleaved cycles -> pointers wrap through 4->0; data order preserved; count never exceeds 5.
- Flush/reset mid-stream: at count=4, flush+put together -> count=0, empty=1, no error flags. Refill 2 words, then reset -> all outputs return to reset values next cycle.
